writeback_ctrl: RTL and testbench
=================================

// Module: writeback_ctrl
// PURPOSE
//  Writeback stage, directly downstream of the memory stage. Consumes the memory stage's
//  flopped outputs, selects the register-file result, drives the write port, and keeps a
//  one-deep registered history of the last retired write for the memory stage's store-data
//  forwarding. Owns HALT retirement: drains, pulses the memory dump, then freezes retirement.
// PARAMETERS
//  DRAIN_CYC  2   cycles held in DRAIN after HALT retires, before DUMP (legal range 1..15)
//  CNT_W      16  width of retire_count
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      synchronous reset, active-high
//  valid_in       in   1      memory-stage outputs hold a real instruction (0 = bubble)
//  stall          in   1      hold: no retirement, no state change this cycle
//  instruction_in in   16     instruction leaving memory stage
//  incrPC         in   16     PC+2 of that instruction
//  Binput         in   16     B operand, already immediate-extended
//  Xcomp          in   16     execute-stage result
//  read_data      in   16     memory load data
//  RegWrt_in      in   1      instruction writes the register file
//  wb_rd          out  3      register-file write address
//  wb_rd_data     out  16     register-file write data
//  wb_en          out  1      register-file write enable
//  wb_rd_delayed      out 3   wb_rd of previous retired write (registered)
//  wb_rd_data_delayed out 16  wb_rd_data of previous retired write (registered)
//  wb_hist_vld    out  1      wb_rd_delayed / wb_rd_data_delayed are valid
//  dump           out  1      one-cycle memory createdump pulse
//  halted         out  1      HALT fully retired; sticky until rst
//  retire_count   out  CNT_W  instructions retired (HALT included)
// BEHAVIOUR
//  - opcode = instruction_in[15:11]. retire = valid_in & ~stall & (state==RUN).
//  - Data select (comb.): 10001 LD -> read_data; 00110/00111 JAL/JALR -> incrPC;
//    11000 LBI -> Binput; all others -> Xcomp.
//  - Dest (comb.): JAL/JALR -> 3'd7; 11000/10010 -> [10:8]; 11001 and 11011/11010/111xx
//    -> [4:2]; all others -> [7:5].
//  - wb_en = retire & RegWrt_in & (opcode != 00000). Same cycle as inputs; zero latency.
//  - History: when wb_en, on clock edge wb_rd_delayed<=wb_rd, wb_rd_data_delayed<=wb_rd_data,
//    wb_hist_vld<=1; otherwise all three hold (bubbles/stalls never clear history).
//  - retire_count += 1 each retire cycle; saturates at all-ones (no wrap).
//  - FSM: RUN -> (retire & opcode==00000) -> DRAIN(load cnt=DRAIN_CYC-1);
//    DRAIN: cnt-- each non-stalled cycle, cnt==0 -> DUMP; DUMP: dump=1 exactly one
//    cycle -> HALTED; HALTED: terminal, halted=1, wb_en=0, no retire.
//  - stall holds FSM and counters in every state, including DRAIN; DUMP proceeds
//    regardless of stall (dump always exactly one cycle).
//  - valid_in ignored outside RUN (younger instructions after HALT never write).
//  - Reset values: wb_rd_delayed=0, wb_rd_data_delayed=0, wb_hist_vld=0, dump=0,
//    halted=0, retire_count=0, FSM=RUN. rst wins over every other input, any state.
// TESTING
//  1 LD r3 (RegWrt=1, read_data=16'hBEEF, Xcomp=16'h0040) -> wb_en=1, wb_rd=3, data=BEEF;
//    next cycle wb_rd_delayed=3, wb_rd_data_delayed=BEEF, wb_hist_vld=1.
//  2 JAL incrPC=16'h0102 -> wb_rd=7, data=0102; ADDI rd=[7:5]=5, Xcomp=16'h0011 -> rd 5.
//  3 Write r2, then bubble, then stall with valid ADD -> wb_en=0 both cycles, history stays r2,
//    retire_count increments once only.
//  4 HALT with DRAIN_CYC=2, ADD r1 valid behind it -> no write of r1, dump high exactly on
//    3rd cycle after HALT, halted=1 thereafter, retire_count frozen.
//  5 stall=1 for 3 cycles in DRAIN -> dump delayed by exactly 3 cycles.
//  6 rst asserted in DRAIN, and counter forced to 16'hFFFF -> saturation holds at FFFF;
//    after rst all outputs at reset values, FSM RUN.

Source files
------------

// File: rtl/writeback_ctrl.sv
// Writeback stage: result select, register-file write port, one-deep retired-write
// history for store-data forwarding, retire counter and HALT drain/dump/freeze sequencing.
module writeback_ctrl #(
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             stall,
    input  logic [15:0]      instruction_in,
    input  logic [15:0]      incrPC,
    input  logic [15:0]      Binput,
    input  logic [15:0]      Xcomp,
    input  logic [15:0]      read_data,
    input  logic             RegWrt_in,
    output logic [2:0]       wb_rd,
    output logic [15:0]      wb_rd_data,
    output logic             wb_en,
    output logic [2:0]       wb_rd_delayed,
    output logic [15:0]      wb_rd_data_delayed,
    output logic             wb_hist_vld,
    output logic             dump,
    output logic             halted,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_HALTED
    } state_t;

    state_t     state;
    logic [3:0] drain_cnt;
    logic [4:0] opcode;
    logic       retire;
    logic       is_halt;
    logic       unused_ins_bits;

    assign opcode          = instruction_in[15:11];
    assign is_halt         = (opcode == 5'b00000);
    assign retire          = valid_in & ~stall & (state == S_RUN);
    assign wb_en           = retire & RegWrt_in & ~is_halt;
    assign unused_ins_bits = ^instruction_in[1:0];

    // Result select and destination decode from the retiring instruction's opcode
    always_comb begin
        wb_rd_data = Xcomp;
        wb_rd      = instruction_in[7:5];
        case (opcode)
            5'b10001: wb_rd_data = read_data;
            5'b00110,
            5'b00111: begin
                wb_rd_data = incrPC;
                wb_rd      = 3'd7;
            end
            5'b11000: begin
                wb_rd_data = Binput;
                wb_rd      = instruction_in[10:8];
            end
            5'b10010: wb_rd = instruction_in[10:8];
            5'b11001,
            5'b11010,
            5'b11011,
            5'b11100,
            5'b11101,
            5'b11110,
            5'b11111: wb_rd = instruction_in[4:2];
            default: ;
        endcase
    end

    // Last retired write, held across bubbles and stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rd_delayed      <= '0;
            wb_rd_data_delayed <= '0;
            wb_hist_vld        <= 1'b0;
        end else if (wb_en) begin
            wb_rd_delayed      <= wb_rd;
            wb_rd_data_delayed <= wb_rd_data;
            wb_hist_vld        <= 1'b1;
        end
    end

    // Saturating count of retired instructions, HALT included
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count <= '0;
        end else if (retire && (retire_count != '1)) begin
            retire_count <= retire_count + 1'b1;
        end
    end

    // HALT sequencing: drain for DRAIN_CYC unstalled cycles, one dump pulse, then freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            drain_cnt <= '0;
            dump      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (retire && is_halt) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 4'(DRAIN_CYC - 1);
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt == '0) begin
                            state <= S_DUMP;
                            dump  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                S_DUMP: begin
                    state  <= S_HALTED;
                    dump   <= 1'b0;
                    halted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Self-checking bench for writeback_ctrl: per-cycle scoreboard of expected writes plus a
// reference model of history, retire count and HALT sequencing; a second instance with a
// narrow counter exercises retire_count saturation.
module tb_writeback_ctrl;

    localparam int DRAIN_CYC = 2;
    localparam int SAT_W     = 4;
    localparam int SAT_MAX   = (1 << SAT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, stall, RegWrt_in;
    logic [15:0] instruction_in, incrPC, Binput, Xcomp, read_data;

    logic [2:0]  wb_rd, wb_rd_delayed;
    logic [15:0] wb_rd_data, wb_rd_data_delayed;
    logic        wb_en, wb_hist_vld, dump, halted;
    logic [15:0] retire_count;

    logic [2:0]       s_rd, s_rd_d;
    logic [15:0]      s_data, s_data_d;
    logic             s_en, s_hv, s_dump, s_halted;
    logic [SAT_W-1:0] s_count;

    always #5 clk = ~clk;

    writeback_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
        .instruction_in(instruction_in), .incrPC(incrPC), .Binput(Binput),
        .Xcomp(Xcomp), .read_data(read_data), .RegWrt_in(RegWrt_in),
        .wb_rd(wb_rd), .wb_rd_data(wb_rd_data), .wb_en(wb_en),
        .wb_rd_delayed(wb_rd_delayed), .wb_rd_data_delayed(wb_rd_data_delayed),
        .wb_hist_vld(wb_hist_vld), .dump(dump), .halted(halted),
        .retire_count(retire_count)
    );

    writeback_ctrl #(.DRAIN_CYC(3), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
        .instruction_in(instruction_in), .incrPC(incrPC), .Binput(Binput),
        .Xcomp(Xcomp), .read_data(read_data), .RegWrt_in(RegWrt_in),
        .wb_rd(s_rd), .wb_rd_data(s_data), .wb_en(s_en),
        .wb_rd_delayed(s_rd_d), .wb_rd_data_delayed(s_data_d),
        .wb_hist_vld(s_hv), .dump(s_dump), .halted(s_halted),
        .retire_count(s_count)
    );

    typedef struct {
        logic        en;
        logic [2:0]  rd;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state (0 RUN, 1 DRAIN, 2 DUMP, 3 HALTED)
    int          m_state, m_dcnt, m_cnt, m_sat;
    logic [2:0]  m_hrd;
    logic [15:0] m_hdata;
    logic        m_hvld;
    logic        last_dump;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_dcnt = 0; m_cnt = 0; m_sat = 0;
        m_hrd = '0; m_hdata = '0; m_hvld = 1'b0;
    endtask

    function automatic exp_t expect_write(input logic [15:0] ins, input logic [15:0] inc,
                                          input logic [15:0] b, input logic [15:0] x,
                                          input logic [15:0] rdd);
        exp_t e;
        logic [4:0] op;
        op     = ins[15:11];
        e.en   = 1'b0;
        e.data = x;
        e.rd   = ins[7:5];
        if (op == 5'b10001) e.data = rdd;
        if (op == 5'b00110 || op == 5'b00111) begin e.data = inc; e.rd = 3'd7; end
        if (op == 5'b11000) e.data = b;
        if (op == 5'b11000 || op == 5'b10010) e.rd = ins[10:8];
        if (op == 5'b11001 || op == 5'b11010 || op == 5'b11011 || op[4:2] == 3'b111)
            e.rd = ins[4:2];
        return e;
    endfunction

    // One clock: drive, push expectation, compare at negedge, advance model at posedge
    task automatic step(input logic v, input logic s, input logic [15:0] ins,
                        input logic [15:0] inc, input logic [15:0] b, input logic [15:0] x,
                        input logic [15:0] rdd, input logic rw);
        exp_t e, got;
        logic ret;
        logic [4:0] op;
        valid_in = v; stall = s; instruction_in = ins; incrPC = inc;
        Binput = b; Xcomp = x; read_data = rdd; RegWrt_in = rw;
        op   = ins[15:11];
        ret  = v & ~s & (m_state == 0);
        e    = expect_write(ins, inc, b, x, rdd);
        e.en = ret & rw & (op != 5'b00000);
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check("wb_en", 32'(wb_en), 32'(got.en));
        if (got.en) begin
            check("wb_rd", 32'(wb_rd), 32'(got.rd));
            check("wb_rd_data", 32'(wb_rd_data), 32'(got.data));
        end
        check("dump", 32'(dump), 32'(m_state == 2));
        check("halted", 32'(halted), 32'(m_state == 3));
        check("hist_vld", 32'(wb_hist_vld), 32'(m_hvld));
        check("hist_rd", 32'(wb_rd_delayed), 32'(m_hrd));
        check("hist_data", 32'(wb_rd_data_delayed), 32'(m_hdata));
        check("retire_count", 32'(retire_count), 32'(m_cnt));
        check("sat_count", 32'(s_count), 32'(m_sat));
        last_dump = dump;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e.en) begin m_hrd = e.rd; m_hdata = e.data; m_hvld = 1'b1; end
            if (ret) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_sat < SAT_MAX) m_sat++;
            end
            case (m_state)
                0: if (ret && op == 5'b00000) begin m_state = 1; m_dcnt = DRAIN_CYC - 1; end
                1: if (!s) begin
                       if (m_dcnt == 0) m_state = 2;
                       else m_dcnt--;
                   end
                2: m_state = 3;
                default: ;
            endcase
        end
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] f1,
                                       input logic [2:0] f2, input logic [2:0] f3);
        return {op, f1, f2, f3, 2'b00};
    endfunction

    task automatic bubble();
        step(1'b0, 1'b0, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic add_r1(input logic s);
        step(1'b1, s, mk(5'b11011, 3'd0, 3'd0, 3'd1), 16'h0, 16'h0, 16'h1111, 16'h0, 1'b1);
    endtask

    task automatic halt();
        step(1'b1, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bubble();
        rst = 1'b0;
    endtask

    int c0;

    initial begin
        rst = 1'b1; valid_in = 1'b0; stall = 1'b0; RegWrt_in = 1'b0;
        instruction_in = '0; incrPC = '0; Binput = '0; Xcomp = '0; read_data = '0;
        last_dump = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state, then LD r3
        bubble();
        step(1'b1, 1'b0, mk(5'b10001, 3'd0, 3'd3, 3'd0), 16'h0, 16'h0, 16'h0040, 16'hBEEF, 1'b1);
        check("t1_hist_rd", 32'(wb_rd_delayed), 32'd3);
        check("t1_hist_data", 32'(wb_rd_data_delayed), 32'hBEEF);
        check("t1_hist_vld", 32'(wb_hist_vld), 32'd1);

        // JAL, ADDI r5, LBI r6, 11001 r4, RegWrt=0
        step(1'b1, 1'b0, mk(5'b00110, 3'd2, 3'd2, 3'd2), 16'h0102, 16'h0, 16'h5555, 16'h0, 1'b1);
        step(1'b1, 1'b0, mk(5'b01000, 3'd0, 3'd5, 3'd0), 16'h0, 16'h0, 16'h0011, 16'h0, 1'b1);
        check("t2_addi_rd", 32'(wb_rd_delayed), 32'd5);
        step(1'b1, 1'b0, mk(5'b11000, 3'd6, 3'd1, 3'd1), 16'h0, 16'h00A5, 16'h7777, 16'h0, 1'b1);
        step(1'b1, 1'b0, mk(5'b11001, 3'd1, 3'd1, 3'd4), 16'h0, 16'h0, 16'h4242, 16'h0, 1'b1);
        step(1'b1, 1'b0, mk(5'b01000, 3'd0, 3'd6, 3'd0), 16'h0, 16'h0, 16'h9999, 16'h0, 1'b0);

        // Write r2, bubble, stalled ADD: history stays r2, count +1 only
        c0 = m_cnt;
        step(1'b1, 1'b0, mk(5'b11011, 3'd0, 3'd0, 3'd2), 16'h0, 16'h0, 16'h2222, 16'h0, 1'b1);
        bubble();
        step(1'b1, 1'b1, mk(5'b11011, 3'd0, 3'd0, 3'd3), 16'h0, 16'h0, 16'h3333, 16'h0, 1'b1);
        check("t3_hist_rd", 32'(wb_rd_delayed), 32'd2);
        check("t3_count", 32'(retire_count), 32'(c0 + 1));

        // Retire enough to saturate the narrow counter
        for (int i = 0; i < 12; i++) add_r1(1'b0);
        check("t6_sat", 32'(s_count), 32'(SAT_MAX));

        // HALT with younger ADD r1 behind it: dump on 3rd cycle after HALT
        halt();
        c0 = m_cnt;
        for (int k = 1; k <= 5; k++) begin
            add_r1(1'b0);
            check("t4_dump_time", 32'(last_dump), 32'(k == 3));
        end
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_count_frozen", 32'(retire_count), 32'(c0));
        do_reset();

        // Stall 3 cycles in DRAIN and during DUMP: dump moves to 6th cycle, still one cycle wide
        halt();
        for (int k = 1; k <= 8; k++) begin
            add_r1(k <= 3 || k == 6);
            check("t5_dump_time", 32'(last_dump), 32'(k == 6));
        end
        check("t5_halted", 32'(halted), 32'd1);
        do_reset();

        // Reset while in DRAIN returns everything to reset values
        add_r1(1'b0);
        halt();
        add_r1(1'b0);
        rst = 1'b1;
        valid_in = 1'b1;
        step(1'b1, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        rst = 1'b0;
        check("t6_rst_count", 32'(retire_count), 32'd0);
        check("t6_rst_hist", 32'(wb_hist_vld), 32'd0);
        check("t6_rst_sat", 32'(s_count), 32'd0);
        bubble();
        add_r1(1'b0);
        check("t6_run_after_rst", 32'(retire_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
